// File: rtl/frame_sender_pkg.sv
// rtl/frame_sender_pkg.sv - shared state encoding and parity constants for the serial frame sender
package frame_sender_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Wide enough for the largest bit index: start + 16 data + parity + 2 stop.
    function automatic int count_w(int data_w);
        return $clog2(data_w + 5);
    endfunction

endpackage

// File: rtl/frame_sender_if.sv
// rtl/frame_sender_if.sv - load/payload handshake and serial line status bundle
interface frame_sender_if
    import frame_sender_pkg::*;
#(
    parameter int DATA_W = 8
) ();

    localparam int CNT_W = count_w(DATA_W);

    logic              load;
    logic [DATA_W-1:0] databyte;
    logic              ready;
    logic              transmitting;
    logic              outbit;
    logic [CNT_W-1:0]  count;

    modport master (
        output load,
        output databyte,
        input  ready,
        input  transmitting,
        input  outbit,
        input  count
    );

    modport slave (
        input  load,
        input  databyte,
        output ready,
        output transmitting,
        output outbit,
        output count
    );

endinterface

// File: rtl/frame_sender_bit_timer.sv
// rtl/frame_sender_bit_timer.sv - per-bit oversample tick counter, pulses bit_done on the last clock of a bit
module bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bit_done
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;

    always_comb begin
        tick_d = tick_q;
        if (!enable || tick_q == LAST_TICK) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign bit_done = enable && (tick_q == LAST_TICK);

endmodule

// File: rtl/frame_sender.sv
// rtl/frame_sender.sv - serial frame transmitter: start, LSB-first payload, optional parity, stop bits
module frame_sender
    import frame_sender_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic           clk,
    input  logic           reset,
    frame_sender_if.slave  bus
);

    localparam int CNT_W = count_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);
    localparam bit ODD_PARITY = (PARITY_MODE == PARITY_ODD);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [CNT_W-1:0]  sub_q, sub_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              outbit_q, outbit_d;
    logic              bit_done;
    logic              ready;
    logic              transmitting;

    bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .enable   (state_q != IDLE),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            par_q    <= 1'b0;
            sub_q    <= '0;
            count_q  <= '0;
            outbit_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            sub_q    <= sub_d;
            count_q  <= count_d;
            outbit_q <= outbit_d;
        end
    end

    // sub_q indexes within the data or stop field; count_q is the frame-wide bit index.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        sub_d   = sub_q;
        count_d = count_q;
        case (state_q)
            IDLE: ;
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    sub_d   = '0;
                    count_d = count_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    count_d = count_q + CNT_W'(1);
                    if (sub_q == LAST_DATA) begin
                        state_d = HAS_PARITY ? PARITY : STOP;
                        sub_d   = '0;
                    end else begin
                        sub_d = sub_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    sub_d   = '0;
                    count_d = count_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (sub_q == LAST_STOP) begin
                        state_d = IDLE;
                        sub_d   = '0;
                        count_d = '0;
                    end else begin
                        sub_d   = sub_q + CNT_W'(1);
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Accepting in the final stop clock chains frames with no idle gap.
        if (ready && bus.load) begin
            state_d = START;
            shift_d = bus.databyte;
            par_d   = (^bus.databyte) ^ ODD_PARITY;
            sub_d   = '0;
            count_d = '0;
        end
    end

    always_comb begin
        ready        = (state_q == IDLE) ||
                       ((state_q == STOP) && (sub_q == LAST_STOP) && bit_done);
        transmitting = (state_q != IDLE);
        outbit_d     = 1'b1;
        case (state_d)
            IDLE:    outbit_d = 1'b1;
            START:   outbit_d = 1'b0;
            DATA:    outbit_d = shift_d[0];
            PARITY:  outbit_d = par_d;
            STOP:    outbit_d = 1'b1;
            default: outbit_d = 1'b1;
        endcase
    end

    assign bus.ready        = ready;
    assign bus.transmitting = transmitting;
    assign bus.outbit       = outbit_q;
    assign bus.count        = count_q;

endmodule

// File: doc/frame_sender.md
FRAME_SENDER -- requirements
Module: frame_sender

Interface
REQ-001: Parameter DATA_W, default 8, SHALL set the number of payload bits per frame (legal 5..16).
REQ-002: Parameter OVERSAMPLE, default 16, SHALL set the clocks per serial bit (legal 2..1024).
REQ-003: Parameter PARITY_MODE, default 0, SHALL select parity: 0 none, 1 even, 2 odd.
REQ-004: Parameter STOP_BITS, default 1, SHALL set the stop bits per frame (legal 1 or 2).
REQ-005: clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006: reset  input  1  SHALL be the synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-007: load  input  1  SHALL request transmission of databyte; it is accepted only when ready=1.
REQ-008: databyte  input  DATA_W  SHALL carry the payload, sampled in the accept cycle.
REQ-009: ready  output  1  SHALL be 1 when a new load will be accepted.
REQ-010: transmitting  output  1  SHALL be 1 while a frame is on the line.
REQ-011: outbit  output  1  SHALL be the registered serial line, idle high.
REQ-012: count  output  $clog2(DATA_W+5)  SHALL give the index of the bit currently driven (0 = start bit).

Function
REQ-013: Frame length N SHALL be 1 + DATA_W + (PARITY_MODE!=0) + STOP_BITS bits; each bit SHALL be held for exactly OVERSAMPLE clocks.
REQ-014: The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE=0.
REQ-015: In IDLE with load=1: capture databyte, go to START; next cycle outbit=0, ready=0, transmitting=1, count=0.
REQ-016: A tick counter SHALL run 0..OVERSAMPLE-1 in non-IDLE states; at OVERSAMPLE-1 the FSM advances to the next bit and count increments.
REQ-017: DATA SHALL shift the payload out LSB first, DATA_W bits.
REQ-018: The parity bit SHALL be the XOR of the payload bits (even) or its complement (odd).
REQ-019: Stop bits SHALL drive outbit=1; after the last stop clock, the FSM SHALL return to IDLE with ready=1, transmitting=0, count=0.
REQ-020: Total occupancy from accept to ready=1 SHALL be N*OVERSAMPLE clocks; back-to-back frames SHALL have no idle gap if load is held.
REQ-021: load while ready=0 SHALL be ignored; databyte changes mid-frame SHALL NOT affect the frame in flight.
REQ-022: The count and tick counters SHALL never exceed N-1 and OVERSAMPLE-1 respectively and SHALL wrap to 0 on return to IDLE.

Reset
REQ-023: With reset=0 at a clock edge: state=IDLE, outbit=1, ready=1, transmitting=0, count=0, counters 0, shift register 0.
REQ-024: Reset asserted mid-frame SHALL abort the frame at the next edge; no partial bits SHALL follow after deassertion.
REQ-025: A load in the same cycle as reset=0 SHALL be discarded.

Structure
REQ-026: Package frame_sender_pkg SHALL hold the state enum and the PARITY_NONE/EVEN/ODD constants.
REQ-027: The tick counter SHALL be a sub-module bit_timer (parameter OVERSAMPLE; inputs enable, outputs bit_done).
REQ-028: outbit SHALL be driven from a flop; no combinational path from load or databyte to outbit.

Verification
REQ-029: Defaults, load 0xA5 -> outbit 0,1,0,1,0,0,1,0,1,1, each 16 clocks; ready=1 exactly 160 clocks after accept.
REQ-030: PARITY_MODE=1, 0xA5 -> parity bit 0; PARITY_MODE=2 -> parity bit 1; frame 176 clocks.
REQ-031: STOP_BITS=2, OVERSAMPLE=4, load held high with 0x3C then 0xC3 -> second start bit immediately after 8 stop clocks, no gap.
REQ-032: Reset=0 at clock 50 of a frame -> next edge outbit=1, ready=1, count=0; no further low bits.
REQ-033: load pulsed at clock 20 of a busy frame with 0xFF -> ignored; the current frame is unchanged and no second frame follows.
REQ-034: DATA_W=16, load 0x8001 -> bit 1 and bit 16 high, others low; count reaches 17 in the stop bit.
